// File: rtl/byte_queue.sv
`default_nettype none
// ============================================================================
// Module   : byte_queue
// Desc     : Byte FIFO fed by a ready/ack capture handshake, registered pop
//            output. Macro BYTE_QUEUE_DROP_EN: acknowledge-and-drop when full,
//            with sticky overflow flag.
// Revision : 1.0
// ============================================================================
module byte_queue #(
    parameter int DEPTH = 8
) (
    input  logic                    clock_100,
    input  logic                    reset,
    input  logic [7:0]              data_in,
    input  logic                    data_ready_in,
    output logic                    ack_out,
    input  logic                    dequeue_in,
    output logic [7:0]              data_out,
    output logic [$clog2(DEPTH):0]  len_out,
    output logic                    empty_out,
    output logic                    full_out,
    output logic                    overflow_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACK      = 2'd1;
    localparam logic [1:0] S_WAIT_LOW = 2'd2;

`ifdef BYTE_QUEUE_DROP_EN
    localparam bit C_DROP_EN = 1'b1;
`else
    localparam bit C_DROP_EN = 1'b0;
`endif

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    data_out_q, data_out_d;
    logic [7:0]    mem_q [DEPTH];
    logic          w_push;
    logic          w_pop;

    assign empty_out = (count_q == '0);
    assign full_out  = (count_q == C_DEPTH);
    assign len_out   = count_q;
    assign data_out  = data_out_q;
    assign w_pop     = dequeue_in && !empty_out;

    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (data_ready_in && (!full_out || C_DROP_EN)) state_d = S_ACK;
            S_ACK:      state_d = S_WAIT_LOW;
            // Upstream must drop ready before another byte can be taken.
            S_WAIT_LOW: if (!data_ready_in) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack_out = (state_q == S_ACK);
        w_push  = (state_q == S_IDLE) && data_ready_in && !full_out;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            data_out_d = mem_q[rd_ptr_q];
        end
        count_d = count_q + CW'(w_push) - CW'(w_pop);
    end

    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is left unreset; entries are only read after being written.
    always_ff @(posedge clock_100) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef BYTE_QUEUE_DROP_EN
    logic overflow_q;

    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if ((state_q == S_IDLE) && data_ready_in && full_out) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_out = overflow_q;
`else
    assign overflow_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/byte_queue.md
BYTE_QUEUE -- requirements
Module: byte_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of byte entries (power of two, 2..16).
REQ-002 SHALL have port clock_100  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port data_in  input  8  byte offered by the upstream serial-to-parallel stage.
REQ-005 SHALL have port data_ready_in  input  1  upstream byte valid; held high until acknowledged.
REQ-006 SHALL have port ack_out  output  1  one-cycle acknowledge to upstream; byte consumed.
REQ-007 SHALL have port dequeue_in  input  1  pop request from consumer, sampled each edge.
REQ-008 SHALL have port data_out  output  8  last popped byte, registered.
REQ-009 SHALL have port len_out  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-010 SHALL have ports empty_out and full_out  output  1 each  len_out==0 and len_out==DEPTH, combinational from registered count.
REQ-011 SHALL have port overflow_out  output  1  sticky byte-dropped flag.

Function
REQ-012 SHALL implement the capture FSM with states IDLE, ACK, WAIT_LOW.
REQ-013 In IDLE with data_ready_in=1 and full_out=0 at an edge, SHALL write data_in at the write pointer, increment the pointer modulo DEPTH, and enter ACK.
REQ-014 In ACK SHALL drive ack_out=1 for exactly one cycle, then enter WAIT_LOW.
REQ-015 In WAIT_LOW SHALL hold ack_out=0 and return to IDLE only on an edge where data_ready_in=0; no byte SHALL be captured in ACK or WAIT_LOW (no double capture).
REQ-016 In IDLE with data_ready_in=1 and full_out=1, SHALL remain in IDLE with ack_out=0 (backpressure), unless REQ-027 applies.
REQ-017 On an edge with dequeue_in=1 and empty_out=0, SHALL load the head entry into data_out, increment the read pointer modulo DEPTH, and decrement the count; data_out valid the cycle after the pop request.
REQ-018 dequeue_in with empty_out=1 SHALL be ignored; data_out, pointers and count unchanged.
REQ-019 Push and pop on the same edge SHALL both occur; count unchanged; full/empty tested on pre-edge count.
REQ-020 Pop from a full queue in the same cycle a push is refused SHALL free one entry; the push is taken on the next IDLE evaluation.
REQ-021 Pointers SHALL wrap DEPTH-1 -> 0 without loss; count SHALL never exceed DEPTH nor drop below 0.
REQ-022 data_out SHALL hold its value between pops.
REQ-023 Byte order out SHALL equal byte order in (FIFO).

Reset
REQ-024 While reset=1, SHALL force state=IDLE, pointers=0, count=0, data_out=8'h00, ack_out=0, overflow_out=0, independent of the clock.
REQ-025 Reset mid-handshake (ACK or WAIT_LOW) SHALL discard queue contents; after release, a still-high data_ready_in is captured as a new byte.
REQ-026 Storage array contents need not be reset; they SHALL be unobservable until written.

Configuration
REQ-027 With macro BYTE_QUEUE_DROP_EN defined, in IDLE with data_ready_in=1 and full_out=1 SHALL enter ACK without writing (byte dropped) and set overflow_out=1 until reset.
REQ-028 Without BYTE_QUEUE_DROP_EN, SHALL apply REQ-016 backpressure and tie overflow_out to 0.

Verification
REQ-029 Reset, then data_in=8'hA5 with data_ready_in held until ack -> ack_out high exactly one cycle, len_out=1, empty_out=0.
REQ-030 Push 8'h01..8'h08 (DEPTH=8) -> full_out=1, len_out=8; ninth offer 8'h09 gets no ack (macro off); one pop -> data_out=8'h01, then 8'h09 acked.
REQ-031 Push 8'h10..8'h13, pop four times -> data_out sequence 10,11,12,13, empty_out=1; fifth pop leaves data_out=8'h13.
REQ-032 At len_out=3, assert push and dequeue_in on the same edge -> len_out stays 3, head byte appears on data_out.
REQ-033 Push/pop 20 bytes interleaved to wrap pointers twice -> output order equals input order, no loss.
REQ-034 BYTE_QUEUE_DROP_EN defined, queue full, offer 8'hFF -> ack_out pulses, len_out stays 8, overflow_out=1 until reset asserted.
